// File: rtl/bscac_gpmux_pipe.sv
// Pipelined per-group candidate MUX with valid/ready output register and 1-entry skid buffer.
// Optional error-beat counter enabled by defining BSCAC_GPMUX_ERRCNT_EN.
module bscac_gpmux_pipe #(
  parameter int NUM_GROUPS = 7,
  parameter int NUM_CAND   = 3,
  parameter int SEL_W      = 2
`ifdef BSCAC_GPMUX_ERRCNT_EN
  ,
  parameter int ERRCNT_W   = 8
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_GROUPS*SEL_W-1:0]    mux_sel,
  input  logic [NUM_GROUPS*NUM_CAND-1:0] cand_tsv_current_state,
  input  logic [NUM_GROUPS*NUM_CAND-1:0] cand_data_2b_trans,
  input  logic [NUM_GROUPS-1:0]          ctrl_signal_bit,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_GROUPS-1:0]          sel_tsv_current_state,
  output logic [NUM_GROUPS-1:0]          sel_data_2b_trans,
  output logic [NUM_GROUPS-1:0]          sel_ctrl_signal_bit,
  output logic [NUM_GROUPS-1:0]          sel_err
`ifdef BSCAC_GPMUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]            err_cnt
`endif
);

  typedef struct packed {
    logic [NUM_GROUPS-1:0] tsv;
    logic [NUM_GROUPS-1:0] trans;
    logic [NUM_GROUPS-1:0] ctrl;
    logic [NUM_GROUPS-1:0] err;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  beat_t  out_q, out_d;
  beat_t  skid_q, skid_d;
  beat_t  mux_beat;
  logic   accept;
  logic   xfer;

  // Out-of-range selects produce zero data and flag the group.
  always_comb begin
    mux_beat = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      mux_beat.ctrl[g] = ctrl_signal_bit[g];
      mux_beat.err[g]  = 1'b1;
      for (int c = 0; c < NUM_CAND; c++) begin
        if (mux_sel[g*SEL_W +: SEL_W] == SEL_W'(c)) begin
          mux_beat.tsv[g]   = cand_tsv_current_state[g*NUM_CAND + c];
          mux_beat.trans[g] = cand_data_2b_trans[g*NUM_CAND + c];
          mux_beat.err[g]   = 1'b0;
        end
      end
    end
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // While the skid is full, in_ready is low, so draining it never races a new beat.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = mux_beat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          out_d = mux_beat;
        end else if (accept) begin
          skid_d  = mux_beat;
          state_d = TWO;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign sel_tsv_current_state = out_q.tsv;
  assign sel_data_2b_trans     = out_q.trans;
  assign sel_ctrl_signal_bit   = out_q.ctrl;
  assign sel_err               = out_q.err;

`ifdef BSCAC_GPMUX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts transferred beats carrying any group error, saturating at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (xfer && (|out_q.err) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_bscac_gpmux_pipe.sv
// Directed and scoreboard-checked bench for bscac_gpmux_pipe (default 7 groups x 3 candidates).
// Error-counter checks are compiled in when BSCAC_GPMUX_ERRCNT_EN is defined.
module tb_bscac_gpmux_pipe;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [13:0] muxSel;
  logic [20:0] candTsv;
  logic [20:0] candTrans;
  logic [6:0]  ctrlBit;
  logic        outValid;
  logic        outReady;
  logic [6:0]  selTsv;
  logic [6:0]  selTrans;
  logic [6:0]  selCtrl;
  logic [6:0]  selErr;
`ifdef BSCAC_GPMUX_ERRCNT_EN
  logic [7:0]  errCnt;
`endif

  logic [27:0] obsBeat;
  assign obsBeat = {selTsv, selTrans, selCtrl, selErr};

  int checkCount = 0;
  int failCount  = 0;

  bscac_gpmux_pipe dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (inValid),
    .in_ready               (inReady),
    .mux_sel                (muxSel),
    .cand_tsv_current_state (candTsv),
    .cand_data_2b_trans     (candTrans),
    .ctrl_signal_bit        (ctrlBit),
    .out_valid              (outValid),
    .out_ready              (outReady),
    .sel_tsv_current_state  (selTsv),
    .sel_data_2b_trans      (selTrans),
    .sel_ctrl_signal_bit    (selCtrl),
    .sel_err                (selErr)
`ifdef BSCAC_GPMUX_ERRCNT_EN
    ,
    .err_cnt                (errCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [13:0] sel, input logic [20:0] tsv,
                               input logic [20:0] trans, input logic [6:0] ctrl);
    inValid   = valid;
    muxSel    = sel;
    candTsv   = tsv;
    candTrans = trans;
    ctrlBit   = ctrl;
  endtask

  // Reference selection written per group with explicit shifts.
  function automatic logic [27:0] refMux(input logic [13:0] sel, input logic [20:0] tsv,
                                         input logic [20:0] trans, input logic [6:0] ctrl);
    logic [6:0] t, d, e;
    int s;
    t = '0; d = '0; e = '0;
    for (int g = 0; g < 7; g++) begin
      s = int'((sel >> (2*g)) & 14'd3);
      if (s < 3) begin
        t[g] = tsv[3*g + s];
        d[g] = trans[3*g + s];
      end else begin
        e[g] = 1'b1;
      end
    end
    return {t, d, ctrl, e};
  endfunction

  logic [27:0] expQ[$];
  logic [27:0] prevBeat, front;
  logic        prevValid, prevReady, mXfer, mAcc;
  logic [13:0] rSel;
  logic [20:0] rTsv, rTrans;
  logic [6:0]  rCtrl;
  int          accepted;
  int          expErr;

  localparam logic [27:0] BEAT_A = {7'h7f, 7'h00, 7'h01, 7'h00};
  localparam logic [27:0] BEAT_B = {7'h7f, 7'h00, 7'h02, 7'h00};
  localparam logic [27:0] BEAT_C = {7'h00, 7'h7f, 7'h04, 7'h00};

  initial begin
    rst = 1'b1;
    outReady = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, inReady}, 32'd1);
    checkOutput("reset_sel", {4'd0, obsBeat}, 32'd0);
`ifdef BSCAC_GPMUX_ERRCNT_EN
    checkOutput("reset_err_cnt", {24'd0, errCnt}, 32'd0);
`endif

    // Group 0 selects candidate 2.
    applyStimulus(1'b1, 14'h0002, 21'h000004, 21'h000001, 7'h00);
    @(negedge clk);
    checkOutput("sel2_out_valid", {31'd0, outValid}, 32'd1);
    checkOutput("sel2_beat", {4'd0, obsBeat}, {4'd0, 7'h01, 7'h00, 7'h00, 7'h00});
    applyStimulus(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("sel2_drained", {31'd0, outValid}, 32'd0);

    // Group 3 out of range, others pick candidate 0 of all-ones inputs.
    applyStimulus(1'b1, 14'h00C0, 21'h1FFFFF, 21'h1FFFFF, 7'h08);
    @(negedge clk);
    checkOutput("err_beat", {4'd0, obsBeat}, {4'd0, 7'h77, 7'h77, 7'h08, 7'h08});
`ifdef BSCAC_GPMUX_ERRCNT_EN
    checkOutput("err_cnt_before", {24'd0, errCnt}, 32'd0);
`endif
    applyStimulus(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("err_drained", {31'd0, outValid}, 32'd0);
`ifdef BSCAC_GPMUX_ERRCNT_EN
    checkOutput("err_cnt_after", {24'd0, errCnt}, 32'd1);
`endif

    // Back-pressure: A held, B parked in skid, C refused until skid drains.
    applyStimulus(1'b1, 14'h0000, {7{3'b001}}, 21'h0, 7'h01);
    @(negedge clk);
    checkOutput("bp_a_valid", {31'd0, outValid}, 32'd1);
    checkOutput("bp_a_beat", {4'd0, obsBeat}, {4'd0, BEAT_A});
    checkOutput("bp_a_in_ready", {31'd0, inReady}, 32'd1);
    applyStimulus(1'b1, 14'h1555, {7{3'b010}}, {7{3'b101}}, 7'h02);
    outReady = 1'b0;
    @(negedge clk);
    checkOutput("bp_skid_in_ready", {31'd0, inReady}, 32'd0);
    checkOutput("bp_a_held", {4'd0, obsBeat}, {4'd0, BEAT_A});
    applyStimulus(1'b1, 14'h2AAA, 21'h0, {7{3'b100}}, 7'h04);
    @(negedge clk);
    checkOutput("bp_still_full", {31'd0, inReady}, 32'd0);
    checkOutput("bp_a_stable", {4'd0, obsBeat}, {4'd0, BEAT_A});
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_b_beat", {4'd0, obsBeat}, {4'd0, BEAT_B});
    checkOutput("bp_b_in_ready", {31'd0, inReady}, 32'd1);
    @(negedge clk);
    checkOutput("bp_c_valid", {31'd0, outValid}, 32'd1);
    checkOutput("bp_c_beat", {4'd0, obsBeat}, {4'd0, BEAT_C});
    applyStimulus(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("bp_drained", {31'd0, outValid}, 32'd0);

    // Reset with both output register and skid occupied.
    outReady = 1'b0;
    applyStimulus(1'b1, 14'h0000, {7{3'b001}}, 21'h0, 7'h01);
    @(negedge clk);
    applyStimulus(1'b1, 14'h1555, {7{3'b010}}, {7{3'b101}}, 7'h02);
    @(negedge clk);
    checkOutput("rst_full_in_ready", {31'd0, inReady}, 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_full_out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_full_in_ready2", {31'd0, inReady}, 32'd1);
    checkOutput("rst_full_sel", {4'd0, obsBeat}, 32'd0);
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_no_ghost", {31'd0, outValid}, 32'd0);
    end

    // Random handshake stream against a queue scoreboard.
    outReady  = 1'b0;
    prevValid = 1'b0;
    prevReady = 1'b0;
    prevBeat  = '0;
    accepted  = 0;
    expErr    = 0;
    for (int cyc = 0; cyc < 60000 && !(accepted == 10000 && expQ.size() == 0); cyc++) begin
      @(negedge clk);
      mXfer = (expQ.size() > 0) && prevReady;
      mAcc  = prevValid && (expQ.size() < 2);
      if (mXfer) begin
        front = expQ.pop_front();
        if ((|front[6:0]) && expErr < 255) expErr++;
      end
      if (mAcc) begin
        expQ.push_back(prevBeat);
        accepted++;
      end
      checkOutput("rand_out_valid", {31'd0, outValid}, {31'd0, expQ.size() > 0});
      checkOutput("rand_in_ready", {31'd0, inReady}, {31'd0, expQ.size() < 2});
      if (expQ.size() > 0) checkOutput("rand_beat", {4'd0, obsBeat}, {4'd0, expQ[0]});
`ifdef BSCAC_GPMUX_ERRCNT_EN
      checkOutput("rand_err_cnt", {24'd0, errCnt}, expErr);
`endif
      rSel   = 14'($urandom);
      rTsv   = 21'($urandom);
      rTrans = 21'($urandom);
      rCtrl  = 7'($urandom);
      prevValid = (accepted < 10000) && ($urandom_range(3) != 0);
      prevReady = (accepted >= 10000) || ($urandom_range(3) != 0);
      prevBeat  = refMux(rSel, rTsv, rTrans, rCtrl);
      applyStimulus(prevValid, rSel, rTsv, rTrans, rCtrl);
      outReady = prevReady;
    end
    checkOutput("rand_accepted", accepted, 10000);
    checkOutput("rand_queue_empty", expQ.size(), 0);

`ifdef BSCAC_GPMUX_ERRCNT_EN
    // 300 error beats saturate the 8-bit counter.
    applyStimulus(1'b0, '0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("sat_err_cnt_reset", {24'd0, errCnt}, 32'd0);
    outReady = 1'b1;
    applyStimulus(1'b1, 14'h0003, '0, '0, '0);
    repeat (300) @(negedge clk);
    applyStimulus(1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("sat_err_cnt", {24'd0, errCnt}, 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
